// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control block and its counter/display datapath.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10,
    StLap   = 2'b11
  } sw_state_e;

  localparam int unsigned DefTickDiv   = 25000000;
  localparam int unsigned DefDebCycles = 1000000;
  localparam logic [15:0] BcdMax       = 16'h9999;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and press-event pulse.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DefDebCycles
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CntW = $clog2(DEB_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEB_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            level_dly_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            press_q, press_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
    // Pulse on the cycle after the debounced level first reads high.
    press_d = level_q & ~level_dly_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      cnt_q       <= '0;
      press_q     <= 1'b0;
    end else begin
      sync1_q     <= btn_i;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      cnt_q       <= cnt_d;
      press_q     <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button conditioning, count prescaler, run/pause/lap FSM and
// counter/display control strobes.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV    = DefTickDiv,
  parameter int unsigned DEB_CYCLES  = DefDebCycles,
  parameter bit          STOP_AT_MAX = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       btn_clear,
  input  logic       cnt_max,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       disp_latch,
  output logic       disp_hold,
  output logic [1:0] state,
  output logic       overflow
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PrescLast = PW'(TICK_DIV - 1);

  logic start_p, lap_p, clear_p;
  logic ev_start, ev_lap, ev_clear;
  logic counting, tick, stop;

  sw_state_e state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic overflow_q, overflow_d;
  logic cnt_en_q, cnt_en_d;
  logic cnt_clr_q, cnt_clr_d;
  logic latch_q, latch_d;
  logic latch_pend_q, latch_pend_d;
  logic hold_q, hold_d;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
    .clk(clk), .rst(rst), .btn_i(btn_start), .press_o(start_p)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lap (
    .clk(clk), .rst(rst), .btn_i(btn_lap), .press_o(lap_p)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
    .clk(clk), .rst(rst), .btn_i(btn_clear), .press_o(clear_p)
  );

  assign ev_clear = clear_p;
  assign ev_start = start_p & ~clear_p;
  assign ev_lap   = lap_p & ~clear_p & ~start_p;

  assign counting = (state_q == StRun) || (state_q == StLap);
  assign tick     = counting && (presc_q == PrescLast);
  assign stop     = tick && cnt_max && STOP_AT_MAX;

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    overflow_d   = overflow_q;
    cnt_en_d     = 1'b0;
    cnt_clr_d    = 1'b0;
    latch_d      = latch_pend_q;
    latch_pend_d = 1'b0;

    if (counting) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
    if (tick) begin
      cnt_en_d = ~stop;
      if (cnt_max) begin
        overflow_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (ev_start) begin
          state_d = StRun;
        end else if (ev_clear) begin
          cnt_clr_d = 1'b1;
          presc_d   = '0;
        end
      end
      StRun: begin
        if (stop || ev_start) begin
          state_d = StPause;
        end else if (ev_lap) begin
          state_d = StLap;
          // Keep the latch strobe off the cnt_en cycle; capture one cycle later instead.
          if (tick) begin
            latch_pend_d = 1'b1;
          end else begin
            latch_d = 1'b1;
          end
        end
      end
      StLap: begin
        if (stop || ev_start) begin
          state_d = StPause;
        end else if (ev_lap) begin
          state_d = StRun;
        end
      end
      StPause: begin
        if (ev_start) begin
          state_d = StRun;
        end else if (ev_clear) begin
          state_d    = StIdle;
          cnt_clr_d  = 1'b1;
          presc_d    = '0;
          overflow_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    hold_d = (state_d == StLap);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      presc_q      <= '0;
      overflow_q   <= 1'b0;
      cnt_en_q     <= 1'b0;
      cnt_clr_q    <= 1'b0;
      latch_q      <= 1'b0;
      latch_pend_q <= 1'b0;
      hold_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      overflow_q   <= overflow_d;
      cnt_en_q     <= cnt_en_d;
      cnt_clr_q    <= cnt_clr_d;
      latch_q      <= latch_d;
      latch_pend_q <= latch_pend_d;
      hold_q       <= hold_d;
    end
  end

  assign state      = state_q;
  assign overflow   = overflow_q;
  assign cnt_en     = cnt_en_q;
  assign cnt_clr    = cnt_clr_q;
  assign disp_latch = latch_q;
  assign disp_hold  = hold_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4, DEB_CYCLES=3, STOP_AT_MAX=1.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_lap = 1'b0;
  logic       btn_clear = 1'b0;
  logic       cnt_max = 1'b0;
  logic       cnt_en, cnt_clr, disp_latch, disp_hold, overflow;
  logic [1:0] state;

  stopwatch_ctrl #(
    .TICK_DIV   (4),
    .DEB_CYCLES (3),
    .STOP_AT_MAX(1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_start (btn_start),
    .btn_lap   (btn_lap),
    .btn_clear (btn_clear),
    .cnt_max   (cnt_max),
    .cnt_en    (cnt_en),
    .cnt_clr   (cnt_clr),
    .disp_latch(disp_latch),
    .disp_hold (disp_hold),
    .state     (state),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Expected output word: {state[1:0], overflow, disp_hold, disp_latch, cnt_clr, cnt_en}
  localparam logic [6:0] IDLE   = 7'b00_0_0_0_0_0;
  localparam logic [6:0] IDLE_C = 7'b00_0_0_0_1_0;
  localparam logic [6:0] RUN    = 7'b01_0_0_0_0_0;
  localparam logic [6:0] RUN_E  = 7'b01_0_0_0_0_1;
  localparam logic [6:0] LAP_H  = 7'b11_0_1_0_0_0;
  localparam logic [6:0] LAP_L  = 7'b11_0_1_1_0_0;
  localparam logic [6:0] LAP_E  = 7'b11_0_1_0_0_1;
  localparam logic [6:0] PAUSE  = 7'b10_0_0_0_0_0;
  localparam logic [6:0] P_OVF  = 7'b10_1_0_0_0_0;

  typedef struct {
    logic       st;
    logic       lp;
    logic       cl;
    logic       mx;
    int         n;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic st, input logic lp, input logic cl, input logic mx,
                     input int n, input logic [6:0] e);
    vec_t v;
    v.st = st; v.lp = lp; v.cl = cl; v.mx = mx; v.n = n; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [6:0] exp);
    logic [6:0] got;
    got = {state, overflow, disp_hold, disp_latch, cnt_clr, cnt_en};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got {st,ovf,hold,latch,clr,en}=%b required %b", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit ok;

    // Bounce in IDLE: three 2-cycle pulses never stay stable long enough.
    for (int i = 0; i < 3; i++) begin
      add(1, 0, 0, 0, 2, IDLE);
      add(0, 0, 0, 0, 1, IDLE);
    end
    add(0, 0, 0, 0, 6, IDLE);
    // Lap ignored in IDLE, clear in IDLE pulses cnt_clr only.
    add(0, 1, 0, 0, 3, IDLE);
    add(0, 0, 0, 0, 6, IDLE);
    add(0, 0, 1, 0, 3, IDLE);
    add(0, 0, 0, 0, 3, IDLE);
    add(0, 0, 0, 0, 1, IDLE_C);
    add(0, 0, 0, 0, 4, IDLE);
    // Start: RUN 6 cycles after the first raw-high edge, ticks on RUN cycles 4, 8, 12.
    add(1, 0, 0, 0, 3, IDLE);
    add(0, 0, 0, 0, 3, IDLE);
    add(0, 0, 0, 0, 1, RUN);
    for (int i = 0; i < 3; i++) begin
      add(0, 0, 0, 0, 3, RUN);
      add(0, 0, 0, 0, 1, RUN_E);
    end
    // Lap in RUN, clear ignored in LAP, second lap back to RUN.
    add(0, 1, 0, 0, 3, RUN);
    add(0, 0, 0, 0, 1, RUN_E);
    add(0, 0, 0, 0, 2, RUN);
    add(0, 0, 1, 0, 1, LAP_L);
    add(0, 0, 1, 0, 1, LAP_E);
    add(0, 0, 1, 0, 1, LAP_H);
    add(0, 0, 0, 0, 2, LAP_H);
    add(0, 0, 0, 0, 1, LAP_E);
    add(0, 1, 0, 0, 3, LAP_H);
    add(0, 0, 0, 0, 1, LAP_E);
    add(0, 0, 0, 0, 2, LAP_H);
    add(0, 0, 0, 0, 1, RUN);
    add(0, 0, 0, 0, 1, RUN_E);
    // Overflow at the next tick: no cnt_en, PAUSE, sticky overflow.
    add(0, 0, 0, 1, 3, RUN);
    add(0, 0, 0, 1, 1, P_OVF);
    add(0, 0, 0, 0, 2, P_OVF);
    // Clear from PAUSE clears overflow and returns to IDLE.
    add(0, 0, 1, 0, 3, P_OVF);
    add(0, 0, 0, 0, 3, P_OVF);
    add(0, 0, 0, 0, 1, IDLE_C);
    add(0, 0, 0, 0, 1, IDLE);
    add(0, 0, 0, 0, 2, IDLE);
    // Fresh RUN: first tick 4 cycles after entry.
    add(1, 0, 0, 0, 3, IDLE);
    add(0, 0, 0, 0, 3, IDLE);
    add(0, 0, 0, 0, 1, RUN);
    add(0, 0, 0, 0, 3, RUN);
    add(0, 0, 0, 0, 1, RUN_E);
    // Pause with prescaler at 2.
    add(0, 0, 0, 0, 3, RUN);
    add(1, 0, 0, 0, 1, RUN_E);
    add(1, 0, 0, 0, 2, RUN);
    add(0, 0, 0, 0, 1, RUN);
    add(0, 0, 0, 0, 1, RUN_E);
    add(0, 0, 0, 0, 1, RUN);
    add(0, 0, 0, 0, 1, PAUSE);
    add(0, 0, 0, 0, 6, PAUSE);
    // Resume: partial progress kept, first cnt_en 2 cycles after re-entering RUN.
    add(1, 0, 0, 0, 3, PAUSE);
    add(0, 0, 0, 0, 3, PAUSE);
    add(0, 0, 0, 0, 2, RUN);
    add(0, 0, 0, 0, 1, RUN_E);
    add(0, 0, 0, 0, 3, RUN);
    add(0, 0, 0, 0, 1, RUN_E);
    // Pause again, then simultaneous start+clear: clear wins.
    add(1, 0, 0, 0, 3, RUN);
    add(0, 0, 0, 0, 1, RUN_E);
    add(0, 0, 0, 0, 2, RUN);
    add(0, 0, 0, 0, 1, PAUSE);
    add(0, 0, 0, 0, 5, PAUSE);
    add(1, 0, 1, 0, 3, PAUSE);
    add(0, 0, 0, 0, 3, PAUSE);
    add(0, 0, 0, 0, 1, IDLE_C);
    add(0, 0, 0, 0, 8, IDLE);

    // Reset state.
    rst = 1'b1;
    step();
    step();
    check("reset", IDLE);
    rst = 1'b0;

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        btn_start = vecs[i].st;
        btn_lap   = vecs[i].lp;
        btn_clear = vecs[i].cl;
        cnt_max   = vecs[i].mx;
        step();
        check($sformatf("vec%0d.%0d", i, k), vecs[i].exp);
      end
    end
    btn_start = 0; btn_lap = 0; btn_clear = 0; cnt_max = 0;

    // Asynchronous reset mid-RUN, between clock edges.
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      btn_start = (i < 3);
      step();
      ok = (state == 2'b01);
    end
    btn_start = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL run_timeout: got state %b required 01 within 20 cycles", state);
    end
    step();
    step();
    #2 rst = 1'b1;
    #1 check("async_reset", IDLE);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("post_reset%0d", i), IDLE);
    end

    // Prescaler restarted from 0 by reset: first tick 4 cycles after RUN entry.
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      btn_start = (i < 3);
      step();
      ok = (state == 2'b01);
    end
    btn_start = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL run_timeout2: got state %b required 01 within 20 cycles", state);
    end
    check("rerun0", RUN);
    for (int i = 1; i < 4; i++) begin
      step();
      check($sformatf("rerun%0d", i), RUN);
    end
    step();
    check("rerun4", RUN_E);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
